// File: rtl/reg_reader.sv
// Read-back sweeper: walks a contiguous register range through a regfile read port and
// streams (regnum, value) pairs on a valid/ready handshake. REG_READER_CHECKSUM_EN adds an XOR checksum output.
module reg_reader #(
  parameter int REG_BITS   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_BITS   = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  direction,
  input  logic [REG_BITS-1:0]   start_reg,
  input  logic [CNT_BITS-1:0]   count,
  output logic [REG_BITS-1:0]   rd_regnum,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_BITS-1:0]   out_regnum,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef REG_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [REG_BITS-1:0] cur;
  logic [CNT_BITS-1:0] remaining;
  logic                dir;

  logic go_accept;
  logic empty_go;
  logic handshake;
  logic last_word;

  assign go_accept = (state == IDLE) && go;
  assign empty_go  = go_accept && (count == '0);
  assign handshake = (state == OUT) && out_ready;
  assign last_word = handshake && (remaining == CNT_BITS'(1));

  // rd_regnum comes straight from a register so it never glitches with inputs.
  assign rd_regnum = cur;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:    if (go_accept && !empty_go) next_state = READ;
      READ:    next_state = OUT;
      OUT:     if (handshake) next_state = last_word ? IDLE : READ;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur        <= '0;
      remaining  <= '0;
      dir        <= 1'b0;
      out_valid  <= 1'b0;
      out_regnum <= '0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      done <= empty_go || last_word;
      case (state)
        IDLE: begin
          if (go_accept && !empty_go) begin
            cur       <= start_reg;
            remaining <= count;
            dir       <= direction;
          end
        end
        READ: begin
          out_regnum <= cur;
          out_data   <= rd_data;
          out_valid  <= 1'b1;
        end
        OUT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            remaining <= remaining - CNT_BITS'(1);
            // Register arithmetic wraps naturally at 2**REG_BITS.
            cur       <= dir ? cur + REG_BITS'(1) : cur - REG_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REG_READER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (go_accept) begin
      checksum <= '0;
    end else if (handshake) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_reg_reader.sv
// Directed bench for reg_reader: sweeps, cadence, backpressure, wrap, edge cases, reset.
// Regfile is modelled in the bench; define REG_READER_CHECKSUM_EN to also check the checksum.
module tb_reg_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        direction = 1'b0;
  logic [4:0]  start_reg = '0;
  logic [5:0]  count = '0;
  logic [4:0]  rd_regnum;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_regnum;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
`ifdef REG_READER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] regs [32];
  int total = 0;
  int bad = 0;
  int done_count = 0;

  assign rd_data = regs[rd_regnum];

  reg_reader dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .direction  (direction),
    .start_reg  (start_reg),
    .count      (count),
    .rd_regnum  (rd_regnum),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_regnum (out_regnum),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
`ifdef REG_READER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_count++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_sweep(input logic [4:0] s, input logic [5:0] c, input logic d);
    start_reg = s;
    count     = c;
    direction = d;
    go        = 1'b1;
    step();
    go = 1'b0;
  endtask

  // Waits for out_valid, checks the word and the wait length, then completes the handshake.
  task automatic expect_word(input string name, input logic [4:0] r, input logic [31:0] d,
                             input int exp_wait);
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
    total++;
    if (out_regnum !== r) begin
      bad++;
      $display("FAIL %s regnum: got %0d required %0d", name, out_regnum, r);
    end
    total++;
    if (out_data !== d) begin
      bad++;
      $display("FAIL %s data: got %h required %h", name, out_data, d);
    end
    if (exp_wait >= 0) begin
      total++;
      if (waited != exp_wait) begin
        bad++;
        $display("FAIL %s cadence: waited %0d required %0d", name, waited, exp_wait);
      end
    end
    step();
  endtask

  task automatic expect_finish(input string name, input int done_before);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end: done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    step();
    total++;
    if (done !== 1'b0 || done_count != done_before + 1) begin
      bad++;
      $display("FAIL %s done pulse: done=%b pulses=%0d required done=0 pulses=1",
               name, done, done_count - done_before);
    end
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_regnum !== 5'd0 ||
        out_data !== 32'd0 || rd_regnum !== 5'd0) begin
      bad++;
      $display("FAIL reset: valid=%b busy=%b done=%b regnum=%0d data=%h rd=%0d required all 0",
               out_valid, busy, done, out_regnum, out_data, rd_regnum);
    end
`ifdef REG_READER_CHECKSUM_EN
    total++;
    if (checksum !== 32'd0) begin
      bad++;
      $display("FAIL reset checksum: got %h required 0", checksum);
    end
`endif
  endtask

  task automatic test_down_sweep();
    int dc = done_count;
    out_ready = 1'b1;
    start_sweep(5'd8, 6'd6, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL down busy: got %b required 1", busy);
    end
    expect_word("down0", 5'd8, 32'hd05, 1);
    expect_word("down1", 5'd7, 32'hd04, 1);
    expect_word("down2", 5'd6, 32'hd03, 1);
    expect_word("down3", 5'd5, 32'hd02, 1);
    expect_word("down4", 5'd4, 32'hd01, 1);
    expect_word("down5", 5'd3, 32'hd00, 1);
`ifdef REG_READER_CHECKSUM_EN
    total++;
    if (checksum !== 32'h001) begin
      bad++;
      $display("FAIL down checksum: got %h required 00000001", checksum);
    end
`endif
    expect_finish("down", dc);
  endtask

  task automatic test_up_sweep();
    int dc = done_count;
    start_sweep(5'd4, 6'd4, 1'b1);
`ifdef REG_READER_CHECKSUM_EN
    total++;
    if (checksum !== 32'd0) begin
      bad++;
      $display("FAIL up checksum clear: got %h required 0", checksum);
    end
`endif
    expect_word("up0", 5'd4, 32'hd01, 1);
    expect_word("up1", 5'd5, 32'hd02, 1);
    expect_word("up2", 5'd6, 32'hd03, 1);
    expect_word("up3", 5'd7, 32'hd04, 1);
    expect_finish("up", dc);
  endtask

  task automatic test_backpressure();
    int dc = done_count;
    out_ready = 1'b1;
    start_sweep(5'd10, 6'd3, 1'b1);
    expect_word("bp0", 5'd10, 32'ha00a, 1);
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_regnum !== 5'd11 || out_data !== 32'ha00b) begin
        bad++;
        $display("FAIL bp hold%0d: valid=%b regnum=%0d data=%h required 1 11 a00b",
                 i, out_valid, out_regnum, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    expect_word("bp1", 5'd11, 32'ha00b, 0);
    expect_word("bp2", 5'd12, 32'ha00c, 1);
    expect_finish("bp", dc);
  endtask

  task automatic test_wrap();
    int dc = done_count;
    start_sweep(5'd30, 6'd4, 1'b1);
    expect_word("wrapup0", 5'd30, 32'ha01e, 1);
    expect_word("wrapup1", 5'd31, 32'ha01f, 1);
    expect_word("wrapup2", 5'd0,  32'ha000, 1);
    expect_word("wrapup3", 5'd1,  32'ha001, 1);
    expect_finish("wrapup", dc);
    dc = done_count;
    start_sweep(5'd1, 6'd3, 1'b0);
    expect_word("wrapdn0", 5'd1,  32'ha001, 1);
    expect_word("wrapdn1", 5'd0,  32'ha000, 1);
    expect_word("wrapdn2", 5'd31, 32'ha01f, 1);
    expect_finish("wrapdn", dc);
  endtask

  task automatic test_count_zero();
    int dc = done_count;
    start_sweep(5'd5, 6'd0, 1'b1);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL zero: busy=%b valid=%b done=%b required 0 0 1", busy, out_valid, done);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL zero after%0d: valid=%b done=%b required 0 0", i, out_valid, done);
      end
    end
    total++;
    if (done_count != dc + 1) begin
      bad++;
      $display("FAIL zero pulses: got %0d required 1", done_count - dc);
    end
  endtask

  task automatic test_go_while_busy();
    int dc = done_count;
    start_sweep(5'd4, 6'd2, 1'b1);
    start_sweep(5'd20, 6'd5, 1'b0);
    expect_word("busygo0", 5'd4, 32'hd01, 0);
    start_reg = 5'd20;
    go = 1'b1;
    expect_word("busygo1", 5'd5, 32'hd02, 1);
    go = 1'b0;
    expect_finish("busygo", dc);
  endtask

  task automatic test_reset_mid();
    int dc;
    out_ready = 1'b0;
    start_sweep(5'd6, 6'd3, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst setup: valid=%b required 1", out_valid);
    end
    dc = done_count;
    reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL midrst: valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
    end
    step();
    reset = 1'b1;
    step();
    total++;
    if (done_count != dc || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst after: pulses=%0d busy=%b required 0 0", done_count - dc, busy);
    end
    out_ready = 1'b1;
    dc = done_count;
    start_sweep(5'd3, 6'd1, 1'b1);
    expect_word("midrst next", 5'd3, 32'hd00, 1);
    expect_finish("midrst next", dc);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'ha000 + 32'(i);
    for (int i = 3; i <= 8; i++) regs[i] = 32'hd00 + 32'(i - 3);
    #3;
    test_reset();
    step();
    reset = 1'b1;
    step();
    test_down_sweep();
    test_up_sweep();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_go_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
